// File: rtl/ysyx_24080014_lsu.sv
// Load/store control stage between EXU and the data-memory port; one request in flight.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return out_err=1 without touching memory.
module ysyx_24080014_lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_ren,
  input  logic          in_wen,
  input  logic [2:0]    in_funct3,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wmask,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_rdata,
  output logic          out_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t        state_r, state_next_s;
  logic          mem_ren_r, mem_wen_r, load_r, uns_r, out_err_r;
  logic [1:0]    size_r, off_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r, out_rdata_r;
  logic [7:0]    mem_wmask_r;
  logic          mem_op_s, misalign_s;

  function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_mask = 4'b0001 << off;
      2'b01:   store_mask = 4'b0011 << (off & 2'b10);
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   store_data = {4{wdata[7:0]}};
      2'b01:   store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = rdata;
    endcase
  endfunction

  assign mem_op_s = in_ren | in_wen;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = mem_op_s &
                      (((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                       (in_funct3[1] & (in_addr[1:0] != 2'b00)));
`else
  assign misalign_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next_s;
  end

  // Next-state logic; trapped or memory-less requests bypass ACCESS.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = (mem_op_s && !misalign_s) ? ACCESS : RESP;
        else          state_next_s = IDLE;
      end
      ACCESS: begin
        if (mem_ready) state_next_s = RESP;
        else           state_next_s = ACCESS;
      end
      RESP: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Request capture, memory-side registers and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ren_r   <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wmask_r <= 8'h00;
      load_r      <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'b00;
      off_r       <= 2'b00;
      out_rdata_r <= '0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mem_addr_r  <= {in_addr[AW-1:2], 2'b00};
            mem_wdata_r <= store_data(in_funct3[1:0], in_wdata);
            mem_wmask_r <= (in_wen && !misalign_s) ? {4'b0000, store_mask(in_funct3[1:0], in_addr[1:0])}
                                                   : 8'h00;
            mem_ren_r   <= in_ren & ~in_wen & ~misalign_s;
            mem_wen_r   <= in_wen & ~misalign_s;
            load_r      <= in_ren & ~in_wen;
            uns_r       <= in_funct3[2];
            size_r      <= in_funct3[1:0];
            off_r       <= in_addr[1:0];
            out_rdata_r <= '0;
            out_err_r   <= misalign_s;
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_ren_r <= 1'b0;
            mem_wen_r <= 1'b0;
            if (load_r) out_rdata_r <= load_extract(size_r, uns_r, off_r, mem_rdata);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == RESP);
  assign mem_ren   = mem_ren_r;
  assign mem_wen   = mem_wen_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wmask = mem_wmask_r;
  assign out_rdata = out_rdata_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed self-checking bench for ysyx_24080014_lsu; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_ysyx_24080014_lsu;
  logic        clk, rst_n;
  logic        in_valid, in_ready, in_ren, in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        mem_ren, mem_wen, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  int errors = 0;
  int checks = 0;

  ysyx_24080014_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request once in_ready is seen (bounded); returns #1 after the accepting edge.
  task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    @(posedge clk); #1;
    in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
  endtask

  task automatic mem_complete(input logic [31:0] rdata);
    mem_rdata = rdata; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic out_accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, mem_ren, mem_wen, out_valid, out_err} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl: {rdy,ren,wen,ov,err}=%b required 10000",
                         {in_ready, mem_ren, mem_wen, out_valid, out_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, out_rdata, mem_wmask} !== 104'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h mask=%h required 0",
                         mem_addr, mem_wdata, out_rdata, mem_wmask);
    end
  endtask

  task automatic test_load_byte_signed();
    issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0);
    checks++;
    if ({mem_ren, mem_wen, in_ready} !== 3'b100 || mem_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL lb_access: ren=%b wen=%b rdy=%b addr=%h required 1 0 0 80000000",
                         mem_ren, mem_wen, in_ready, mem_addr);
    end
    mem_complete(32'h80FF_1234);
    checks++;
    if (out_valid !== 1'b1 || out_rdata !== 32'hFFFF_FF80 || mem_ren !== 1'b0 || out_err !== 1'b0) begin
      errors++; $display("FAIL lb_result: ov=%b rdata=%h ren=%b err=%b required 1 ffffff80 0 0",
                         out_valid, out_rdata, mem_ren, out_err);
    end
    out_accept();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL lb_done: ov=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_noop();
    issue(1'b0, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || out_rdata !== 32'h0 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL noop: ov=%b rdata=%h ren=%b wen=%b required 1 0 0 0",
                         out_valid, out_rdata, mem_ren, mem_wen);
    end
    out_accept();
  endtask

  task automatic test_loads_misc();
    issue(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0);
    mem_complete(32'hBEEF_0000);
    checks++;
    if (out_rdata !== 32'h0000_BEEF) begin
      errors++; $display("FAIL lhu: rdata=%h required 0000beef", out_rdata);
    end
    out_accept();
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0004, 32'h0);
    mem_complete(32'h1234_8001);
    checks++;
    if (out_rdata !== 32'hFFFF_8001) begin
      errors++; $display("FAIL lh: rdata=%h required ffff8001", out_rdata);
    end
    out_accept();
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0009, 32'h0);
    mem_complete(32'h0000_A500);
    checks++;
    if (out_rdata !== 32'h0000_00A5 || mem_addr !== 32'h0000_0008) begin
      errors++; $display("FAIL lbu: rdata=%h addr=%h required 000000a5 00000008", out_rdata, mem_addr);
    end
    out_accept();
  endtask

  task automatic test_stores();
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0012, 32'h0000_00AB);
    checks++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_wmask !== 8'h04 || mem_wdata !== 32'hABAB_ABAB ||
        mem_addr !== 32'h0000_0010) begin
      errors++; $display("FAIL sb: wen=%b ren=%b mask=%h wdata=%h addr=%h required 1 0 04 abababab 00000010",
                         mem_wen, mem_ren, mem_wmask, mem_wdata, mem_addr);
    end
    mem_complete(32'hFFFF_FFFF);
    checks++;
    if (out_rdata !== 32'h0 || mem_wen !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL sb_result: rdata=%h wen=%b ov=%b required 0 0 1", out_rdata, mem_wen, out_valid);
    end
    out_accept();
    issue(1'b1, 1'b1, 3'b001, 32'h0000_0006, 32'h1111_BEEF);
    checks++;
    if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_wmask !== 8'h0C || mem_wdata !== 32'hBEEF_BEEF) begin
      errors++; $display("FAIL sh: wen=%b ren=%b mask=%h wdata=%h required 1 0 0c beefbeef",
                         mem_wen, mem_ren, mem_wmask, mem_wdata);
    end
    mem_complete(32'h0);
    out_accept();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      if (mem_wen !== 1'b1 || mem_addr !== 32'h0000_0020 || mem_wdata !== 32'h1234_5678 ||
          mem_wmask !== 8'h0F || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_access: %0d unstable cycles required 0 (wen=%b addr=%h mask=%h)",
                         bad, mem_wen, mem_addr, mem_wmask);
    end
    mem_complete(32'h0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rdata !== 32'h0 || mem_wen !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_resp: %0d bad cycles required 0 (ov=%b rdy=%b)", bad, out_valid, in_ready);
    end
    out_accept();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: rdy=%b ov=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_misaligned_word();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++;
    if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1 || out_rdata !== 32'h0) begin
      errors++; $display("FAIL mis_trap: ren=%b wen=%b ov=%b err=%b rdata=%h required 0 0 1 1 0",
                         mem_ren, mem_wen, out_valid, out_err, out_rdata);
    end
    out_accept();
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0005, 32'h0);
    checks++;
    if (mem_wen !== 1'b0 || out_err !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mis_half_trap: wen=%b err=%b ov=%b required 0 1 1", mem_wen, out_err, out_valid);
    end
    out_accept();
`else
    checks++;
    if (mem_ren !== 1'b1 || mem_addr !== 32'h0 || out_err !== 1'b0) begin
      errors++; $display("FAIL mis_access: ren=%b addr=%h err=%b required 1 0 0", mem_ren, mem_addr, out_err);
    end
    mem_complete(32'hCAFE_BABE);
    checks++;
    if (out_rdata !== 32'hCAFE_BABE || out_err !== 1'b0) begin
      errors++; $display("FAIL mis_result: rdata=%h err=%b required cafebabe 0", out_rdata, out_err);
    end
    out_accept();
`endif
  endtask

  task automatic test_reset_access();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    checks++;
    if (mem_ren !== 1'b1) begin
      errors++; $display("FAIL rst_pre: ren=%b required 1", mem_ren);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_ren, mem_wen, out_valid, out_err, in_ready} !== 5'b00001 || mem_addr !== 32'h0 ||
        out_rdata !== 32'h0 || mem_wmask !== 8'h00) begin
      errors++; $display("FAIL rst_mid: ren=%b wen=%b ov=%b err=%b rdy=%b addr=%h required 0 0 0 0 1 0",
                         mem_ren, mem_wen, out_valid, out_err, in_ready, mem_addr);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || mem_ren !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_after: rdy=%b ren=%b ov=%b required 1 0 0", in_ready, mem_ren, out_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_funct3 = 3'b000;
    in_addr = 32'h0; in_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0; out_ready = 1'b0;
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_load_byte_signed();
    test_noop();
    test_loads_misc();
    test_stores();
    test_back_to_back();
    test_misaligned_word();
    test_reset_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
